// File: rtl/ble.sv
// Basic logic element: 4-input LUT, optional output flip-flop and optional
// output inverter (compiled in with BLE_OUT_INVERT_EN), configured by a 19-bit serial chain.
module ble (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       prog_clk,
  input  logic       prog_en,
  input  logic       prog_in,
  output logic       prog_out,
  input  logic [3:0] in,
  output logic       out
);

  logic [18:0] cfg;
  logic [15:0] lut;
  logic        reg_sel;
  logic        ff_en;
  logic        lut_o;
  logic        q;
  logic        sel_o;

  // Chain shifts toward bit 0 so a word is loaded LSB first and bit 0 feeds the next BLE.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge prog_clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg <= '0;
    end else if (prog_en) begin
      cfg <= {prog_in, cfg[18:1]};
    end
  end

  assign prog_out = cfg[0];
  assign reg_sel  = cfg[0];
  assign ff_en    = cfg[1];
  assign lut      = cfg[18:3];
  assign lut_o    = lut[in];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (ff_en) begin
      q <= lut_o;
    end
  end

  assign sel_o = reg_sel ? q : lut_o;

`ifdef BLE_OUT_INVERT_EN
  logic out_inv;
  assign out_inv = cfg[2];
  assign out     = sel_o ^ out_inv;
`else
  // cfg[2] still travels through the chain to keep bitstreams compatible; it is ignored here.
  assign out = sel_o;
`endif

endmodule

// File: tb/tb_ble.sv
// Directed self-checking bench for the ble configuration chain, LUT, flip-flop and inverter.
module tb_ble;

  logic       clk;
  logic       rst_n;
  logic       prog_clk;
  logic       prog_en;
  logic       prog_in;
  logic       prog_out;
  logic [3:0] in;
  logic       out;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [18:0] W_ZERO  = 19'b0;
  localparam logic [18:0] W_AAAA  = 19'b1010101010101010000;
  localparam logic [18:0] W_FF00  = 19'b1111111100000000000;
  localparam logic [18:0] W_REG   = {16'hAAAA, 3'b011};
  localparam logic [18:0] W_HOLD  = {16'hAAAA, 3'b001};
  localparam logic [18:0] W_INV   = {16'hAAAA, 3'b100};

`ifdef BLE_OUT_INVERT_EN
  localparam logic INV_ON = 1'b1;
`else
  localparam logic INV_ON = 1'b0;
`endif

  ble dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .prog_clk (prog_clk),
    .prog_en  (prog_en),
    .prog_in  (prog_in),
    .prog_out (prog_out),
    .in       (in),
    .out      (out)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic pulse_clk();
    clk = 1'b1;
    #5;
    clk = 1'b0;
    #5;
  endtask

  task automatic shift_bit(input logic b);
    prog_in  = b;
    prog_en  = 1'b1;
    #2;
    prog_clk = 1'b1;
    #5;
    prog_clk = 1'b0;
    #3;
    prog_en  = 1'b0;
  endtask

  // Loads a word LSB first; optionally checks prog_out shows old bit k before shift k.
  task automatic load(input logic [18:0] word, input logic chk_prev, input logic [18:0] prev,
                      input string tag);
    for (int k = 0; k < 19; k++) begin
      if (chk_prev) check($sformatf("%s prog_out[%0d]", tag, k), prog_out, prev[k]);
      shift_bit(word[k]);
    end
  endtask

  task automatic set_in(input logic [3:0] v);
    in = v;
    #1;
  endtask

  initial begin
    clk = 0; prog_clk = 0; prog_en = 0; prog_in = 0; in = 4'd0;
    rst_n = 1'b0;
    #3;
    check("reset out", out, 1'b0);
    check("reset prog_out", prog_out, 1'b0);
    #5 rst_n = 1'b1;
    #2;

    // All-zero word: every LUT entry 0.
    load(W_ZERO, 1'b1, W_ZERO, "zero");
    for (int i = 0; i < 16; i++) begin
      set_in(4'(i));
      check($sformatf("zero in=%0d", i), out, 1'b0);
    end

    // LUT 0xAAAA combinational: out follows in[0], clk has no effect.
    load(W_AAAA, 1'b1, W_ZERO, "aaaa");
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      set_in(v);
      check($sformatf("aaaa in=%0d", i), out, v[0]);
      pulse_clk();
      check($sformatf("aaaa clk in=%0d", i), out, v[0]);
    end

    // LUT 0xFF00: out = in[3]; 16 wraps to 0.
    load(W_FF00, 1'b1, W_AAAA, "ff00");
    for (int i = 0; i <= 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      set_in(v);
      check($sformatf("ff00 in=%0d", i), out, v[3]);
    end

    // Registered path: one-cycle latency through the flip-flop.
    load(W_REG, 1'b0, W_ZERO, "reg");
    set_in(4'd1);
    check("reg before edge", out, 1'b0);
    pulse_clk();
    check("reg after edge in=1", out, 1'b1);
    set_in(4'd2);
    check("reg hold until edge", out, 1'b1);
    pulse_clk();
    check("reg after edge in=2", out, 1'b0);
    set_in(4'd3);
    pulse_clk();
    check("reg after edge in=3", out, 1'b1);

    // ff_en=0: q holds its value across clk edges.
    load(W_HOLD, 1'b0, W_ZERO, "hold");
    check("hold after load", out, 1'b1);
    set_in(4'd0);
    pulse_clk();
    check("hold after edge in=0", out, 1'b1);
    pulse_clk();
    check("hold after 2nd edge", out, 1'b1);

    // Output inverter (active only when compiled in).
    load(W_INV, 1'b0, W_ZERO, "inv");
    for (int i = 0; i < 4; i++) begin
      logic [3:0] v;
      v = 4'(i);
      set_in(v);
      check($sformatf("inv in=%0d", i), out, v[0] ^ INV_ON);
    end

    // Reset during a partial load: 10 shifts leave old cfg[10] (lut[7]=1) at prog_out.
    for (int k = 0; k < 10; k++) shift_bit(W_AAAA[k]);
    check("partial prog_out", prog_out, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid-load reset out", out, 1'b0);
    check("mid-load reset prog_out", prog_out, 1'b0);
    #4 rst_n = 1'b1;
    #2;
    set_in(4'd1);
    check("post-reset out in=1", out, 1'b0);

    // Full reload restores function.
    load(W_AAAA, 1'b1, W_ZERO, "reload");
    for (int i = 0; i < 16; i += 5) begin
      logic [3:0] v;
      v = 4'(i);
      set_in(v);
      check($sformatf("reload in=%0d", i), out, v[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
